// File: rtl/dq_seq_pkg.sv
// Shared encodings for the DQ-form micro-op sequencer: opType values,
// sequencer FSM states and the doubleword stride between the two micro-ops.
package dq_seq_pkg;

  typedef enum logic [1:0] {
    DQ_OP_LQ   = 2'd0,
    DQ_OP_LXV  = 2'd1,
    DQ_OP_STXV = 2'd2,
    DQ_OP_RSVD = 2'd3
  } dq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UOP0 = 2'd1,
    ST_UOP1 = 2'd2
  } dq_state_e;

  localparam int unsigned DQ_UOP_STRIDE = 8;

endpackage

// File: rtl/dq_form_check.sv
// lq illegal-form detector: an odd RTp, or RTp equal to RA, makes lq illegal.
// Only instantiated when DQ_SEQ_ILLEGAL_CHECK_EN is defined.
module dq_form_check
  import dq_seq_pkg::*;
#(
  parameter int regWidth = 5
) (
  input  logic [1:0]          opType,
  input  logic [regWidth-1:0] rtp,
  input  logic [regWidth-1:0] ra,
  output logic                illegal
);

  assign illegal = (opType == DQ_OP_LQ) && (rtp[0] || (rtp == ra));

endmodule

// File: rtl/dq_uop_sequencer.sv
// Cracks lq / lxv / stxv into two 64-bit memory micro-ops issued over valid/ready.
// Build option DQ_SEQ_ILLEGAL_CHECK_EN enables the lq illegal-form check.
//
// state   | meaning
// IDLE    | no instruction held; decoder may present a new one
// UOP0    | first doubleword micro-op presented (offset = base)
// UOP1    | second doubleword micro-op presented (offset = base+8, last=1)
module dq_uop_sequencer
  import dq_seq_pkg::*;
#(
  parameter int regWidth = 5,
  parameter int immWidth = 12,
  parameter int offWidth = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [1:0]          opType_i,
  input  logic [regWidth-1:0] reg1_i,
  input  logic [regWidth-1:0] reg2_i,
  input  logic [immWidth-1:0] imm_i,
  input  logic                bit_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                illegal_o,
  output logic                uopValid_o,
  input  logic                uopReady_i,
  output logic                uopStore_o,
  output logic                uopVsx_o,
  output logic [regWidth:0]   uopReg_o,
  output logic [regWidth-1:0] uopBase_o,
  output logic [offWidth-1:0] uopOffset_o,
  output logic                uopLast_o
);

  dq_state_e             state;
  logic [regWidth:0]     reg1_hold;
  logic [offWidth-1:0]   off1_hold;

  logic                  accept;
  logic                  form_bad;
  logic                  is_lq;
  logic                  handshake;
  logic [offWidth-1:0]   disp;
  logic [regWidth-1:0]   rt_next;
  logic [regWidth:0]     reg0_sel;
  logic [regWidth:0]     reg1_sel;

  assign is_lq     = (opType_i == DQ_OP_LQ);
  assign accept    = enable_i && !stall_o && !flush_i && (opType_i != DQ_OP_RSVD);
  assign handshake = uopValid_o && uopReady_i;

  // The DQ field is a quadword-scaled displacement; the low nibble is always zero,
  // so OR-ing in the stride yields base+8 without a carry chain.
  assign disp     = offWidth'(signed'({imm_i, 4'b0000}));
  assign rt_next  = reg1_i + regWidth'(1);
  assign reg0_sel = is_lq ? {1'b0, reg1_i}  : {bit_i, reg1_i};
  assign reg1_sel = is_lq ? {1'b0, rt_next} : {bit_i, reg1_i};

`ifdef DQ_SEQ_ILLEGAL_CHECK_EN
  dq_form_check #(
    .regWidth(regWidth)
  ) u_form_check (
    .opType (opType_i),
    .rtp    (reg1_i),
    .ra     (reg2_i),
    .illegal(form_bad)
  );
`else
  assign form_bad = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      stall_o     <= 1'b0;
      illegal_o   <= 1'b0;
      uopValid_o  <= 1'b0;
      uopStore_o  <= 1'b0;
      uopVsx_o    <= 1'b0;
      uopReg_o    <= '0;
      uopBase_o   <= '0;
      uopOffset_o <= '0;
      uopLast_o   <= 1'b0;
      reg1_hold   <= '0;
      off1_hold   <= '0;
    end else begin
      illegal_o <= 1'b0;
      if (flush_i) begin
        state      <= ST_IDLE;
        uopValid_o <= 1'b0;
        stall_o    <= 1'b0;
        uopLast_o  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (form_bad) begin
                illegal_o <= 1'b1;
              end else begin
                state       <= ST_UOP0;
                uopValid_o  <= 1'b1;
                stall_o     <= 1'b1;
                uopLast_o   <= 1'b0;
                uopStore_o  <= (opType_i == DQ_OP_STXV);
                uopVsx_o    <= !is_lq;
                uopReg_o    <= reg0_sel;
                uopBase_o   <= reg2_i;
                uopOffset_o <= disp;
                reg1_hold   <= reg1_sel;
                off1_hold   <= disp | offWidth'(DQ_UOP_STRIDE);
              end
            end
          end
          ST_UOP0: begin
            if (handshake) begin
              state       <= ST_UOP1;
              uopReg_o    <= reg1_hold;
              uopOffset_o <= off1_hold;
              uopLast_o   <= 1'b1;
            end
          end
          ST_UOP1: begin
            if (handshake) begin
              state      <= ST_IDLE;
              uopValid_o <= 1'b0;
              stall_o    <= 1'b0;
              uopLast_o  <= 1'b0;
            end
          end
          default: begin
            state      <= ST_IDLE;
            uopValid_o <= 1'b0;
            stall_o    <= 1'b0;
            uopLast_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dq_uop_sequencer.sv
// Directed and randomized bench for dq_uop_sequencer against a transaction-level
// model: each accepted instruction pushes its two expected micro-ops into a queue.
module tb_dq_uop_sequencer;

`ifdef DQ_SEQ_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic        store;
    logic        vsx;
    logic [5:0]  rg;
    logic [4:0]  base;
    logic [15:0] off;
    logic        last;
  } uop_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  op_type = 2'd0;
  logic [4:0]  reg1 = 5'd0;
  logic [4:0]  reg2 = 5'd0;
  logic [11:0] imm = 12'd0;
  logic        bit_tx = 1'b0;
  logic        flush = 1'b0;
  logic        uop_ready = 1'b0;
  logic        stall, illegal, uop_valid, uop_store, uop_vsx, uop_last;
  logic [5:0]  uop_reg;
  logic [4:0]  uop_base;
  logic [15:0] uop_offset;

  uop_t q[$];
  logic exp_ill = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dq_uop_sequencer dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .enable_i   (enable),
    .opType_i   (op_type),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .imm_i      (imm),
    .bit_i      (bit_tx),
    .flush_i    (flush),
    .stall_o    (stall),
    .illegal_o  (illegal),
    .uopValid_o (uop_valid),
    .uopReady_i (uop_ready),
    .uopStore_o (uop_store),
    .uopVsx_o   (uop_vsx),
    .uopReg_o   (uop_reg),
    .uopBase_o  (uop_base),
    .uopOffset_o(uop_offset),
    .uopLast_o  (uop_last)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [11:0] im, input logic bt,
                       input logic fl, input logic rdy);
    enable = en; op_type = op; reg1 = r1; reg2 = r2; imm = im;
    bit_tx = bt; flush = fl; uop_ready = rdy;
  endtask

  task automatic check_model();
    chk("valid",   32'(uop_valid), 32'(q.size() > 0));
    chk("stall",   32'(stall),     32'(q.size() > 0));
    chk("illegal", 32'(illegal),   32'(exp_ill));
    if (q.size() > 0) begin
      chk("store",  32'(uop_store),  32'(q[0].store));
      chk("vsx",    32'(uop_vsx),    32'(q[0].vsx));
      chk("reg",    32'(uop_reg),    32'(q[0].rg));
      chk("base",   32'(uop_base),   32'(q[0].base));
      chk("offset", 32'(uop_offset), 32'(q[0].off));
      chk("last",   32'(uop_last),   32'(q[0].last));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stall"},   32'(stall),      32'(0));
    chk({tag, "_illegal"}, 32'(illegal),    32'(0));
    chk({tag, "_valid"},   32'(uop_valid),  32'(0));
    chk({tag, "_store"},   32'(uop_store),  32'(0));
    chk({tag, "_vsx"},     32'(uop_vsx),    32'(0));
    chk({tag, "_last"},    32'(uop_last),   32'(0));
    chk({tag, "_reg"},     32'(uop_reg),    32'(0));
    chk({tag, "_base"},    32'(uop_base),   32'(0));
    chk({tag, "_offset"},  32'(uop_offset), 32'(0));
  endtask

  // Advance one clock: predict from the inputs currently driven, then compare.
  task automatic tick();
    logic hs, acc, ill_n, fl_s;
    uop_t u0, u1;
    int   d;
    fl_s  = flush;
    hs    = (q.size() > 0) && uop_ready;
    acc   = enable && (q.size() == 0) && !flush && (op_type != 2'd3);
    ill_n = 1'b0;
    if (acc && CHECK_EN && op_type == 2'd0 && (reg1[0] || reg1 == reg2)) begin
      ill_n = 1'b1;
      acc   = 1'b0;
    end
    d        = int'($signed(imm)) * 16;
    u0.store = (op_type == 2'd2);
    u0.vsx   = (op_type != 2'd0);
    u0.rg    = (op_type == 2'd0) ? 6'(reg1) : 6'(int'(bit_tx) * 32 + int'(reg1));
    u0.base  = reg2;
    u0.off   = 16'(d);
    u0.last  = 1'b0;
    u1       = u0;
    u1.off   = 16'(d + 8);
    u1.last  = 1'b1;
    if (op_type == 2'd0) u1.rg = 6'((int'(reg1) + 1) % 32);
    @(posedge clock);
    #1;
    if (fl_s) q.delete();
    else begin
      if (hs) void'(q.pop_front());
      if (acc) begin
        q.push_back(u0);
        q.push_back(u1);
      end
    end
    exp_ill = ill_n;
    check_model();
  endtask

  initial begin
    #2;
    check_reset_vals("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // lq RT=4 RA=3 DQ=1, ready high
    drive(1, 2'd0, 5'd4, 5'd3, 12'h001, 0, 0, 1);
    tick();
    chk("lq_u0_reg", 32'(uop_reg), 32'd4);
    chk("lq_u0_off", 32'(uop_offset), 32'h0010);
    chk("lq_u0_base", 32'(uop_base), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("lq_u1_reg", 32'(uop_reg), 32'd5);
    chk("lq_u1_off", 32'(uop_offset), 32'h0018);
    chk("lq_u1_last", 32'(uop_last), 32'd1);
    chk("lq_u1_stall", 32'(stall), 32'd1);
    tick();
    chk("lq_done_stall", 32'(stall), 32'd0);

    // lxv T=2 TX=1 DQ=FFF
    drive(1, 2'd1, 5'd2, 5'd7, 12'hFFF, 1, 0, 1);
    tick();
    chk("lxv_u0_reg", 32'(uop_reg), 32'd34);
    chk("lxv_u0_off", 32'(uop_offset), 32'hFFF0);
    chk("lxv_u0_vsx", 32'(uop_vsx), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("lxv_u1_off", 32'(uop_offset), 32'hFFF8);
    chk("lxv_u1_reg", 32'(uop_reg), 32'd34);
    tick();

    // stxv with ready low for three cycles on uop0
    drive(1, 2'd2, 5'd9, 5'd1, 12'h123, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick();
    chk("stxv_hold_store", 32'(uop_store), 32'd1);
    chk("stxv_hold_last", 32'(uop_last), 32'd0);
    chk("stxv_hold_off", 32'(uop_offset), 32'h1230);
    uop_ready = 1'b1;
    tick();
    chk("stxv_u1_last", 32'(uop_last), 32'd1);
    chk("stxv_u1_off", 32'(uop_offset), 32'h1238);
    tick();

    // lq RT=5 RA=1: illegal with the check, cracked to 5/6 without
    drive(1, 2'd0, 5'd5, 5'd1, 12'h002, 0, 0, 1);
    tick();
`ifdef DQ_SEQ_ILLEGAL_CHECK_EN
    chk("lq_odd_illegal", 32'(illegal), 32'd1);
    chk("lq_odd_novalid", 32'(uop_valid), 32'd0);
`else
    chk("lq_odd_u0_reg", 32'(uop_reg), 32'd5);
    chk("lq_odd_illegal0", 32'(illegal), 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
`ifdef DQ_SEQ_ILLEGAL_CHECK_EN
    chk("lq_odd_pulse_end", 32'(illegal), 32'd0);
`else
    chk("lq_odd_u1_reg", 32'(uop_reg), 32'd6);
`endif
    tick();

    // flush while in UOP1 with ready low; enable in the flush cycle ignored
    drive(1, 2'd0, 5'd8, 5'd2, 12'h040, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 2'd1, 5'd3, 5'd4, 12'h010, 0, 1, 0);
    tick();
    chk("flush_valid", 32'(uop_valid), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("flush_no_accept", 32'(uop_valid), 32'd0);

    // reset pulsed mid-UOP0
    drive(1, 2'd0, 5'd12, 5'd6, 12'h005, 0, 0, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    q.delete();
    exp_ill = 1'b0;
    reset = 1'b0;
    drive(1, 2'd0, 5'd10, 5'd4, 12'h007, 0, 0, 1);
    tick();
    chk("post_reset_reg", 32'(uop_reg), 32'd10);
    chk("post_reset_off", 32'(uop_offset), 32'h0070);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r1, r2,
            12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
